mem_arbiter: RTL and testbench

- Single-port memory arbiter between the instruction fetch path and the data memory path of the pipelined CPU.
- Serialises iREN and dREN/dWEN requests onto one RAM port and waits for the RAM to report completion.
- Returns ihit and dhit to the pipeline; these are the hit strobes that gate the pipeline latches, including the MEM/WB latch.
- Data requests have priority, with a bounded-starvation guarantee for instruction fetch.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU memory-side types: RAM status, data word and arbiter state.
// Imported by the arbiter, its interface and its bench.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arbstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline <-> arbiter <-> RAM signal bundle, plus the arbiter's debug view.
// Handshake: a requester raises iREN or dREN/dWEN and holds address/data steady until its
// one-cycle hit strobe; dropping the request before the hit abandons it without a hit.
interface mem_arbiter_if #(
  parameter int CNT_W = 4
);

  logic                      iREN;
  cpu_types_pkg::word_t      iaddr;
  cpu_types_pkg::word_t      iload;
  logic                      ihit;
  logic                      dREN;
  logic                      dWEN;
  cpu_types_pkg::word_t      daddr;
  cpu_types_pkg::word_t      dstore;
  cpu_types_pkg::word_t      dload;
  logic                      dhit;
  logic                      ramREN;
  logic                      ramWEN;
  cpu_types_pkg::word_t      ramaddr;
  cpu_types_pkg::word_t      ramstore;
  cpu_types_pkg::word_t      ramload;
  cpu_types_pkg::ramstate_t  ramstate;
  logic                      memerr;
  cpu_types_pkg::arbstate_t  state;
  logic [CNT_W-1:0]          starve_cnt;

  modport ar (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, memerr,
           state, starve_cnt
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, memerr,
           state, starve_cnt
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests win, but instruction fetch is forced through
// after STARVE_LIMIT consecutive data completions while a fetch is waiting.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input logic       CLK,
  input logic       nRST,
  mem_arbiter_if.ar bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arbstate_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic d_req;
  logic i_act, d_act;
  logic ihit, dhit, done;

  function automatic arbstate_t pick(input logic i_req, input logic dr,
                                     input logic [CNT_W-1:0] cnt);
    arbstate_t nxt;
    if (i_req && dr)  nxt = (cnt >= LIMIT) ? IGRANT : DGRANT;
    else if (dr)      nxt = DGRANT;
    else if (i_req)   nxt = IGRANT;
    else              nxt = IDLE;
    return nxt;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    d_req = bus.dREN | bus.dWEN;
    // An access is live only while the granted requester still asks for it.
    i_act = (state_q == IGRANT) && bus.iREN;
    d_act = (state_q == DGRANT) && d_req;
    ihit  = i_act && (bus.ramstate == ACCESS);
    dhit  = d_act && (bus.ramstate == ACCESS);
    done  = (i_act || d_act) && ((bus.ramstate == ACCESS) || (bus.ramstate == ERROR));

    cnt_d = cnt_q;
    if (!bus.iREN || ihit)        cnt_d = '0;
    else if (dhit && cnt_q < LIMIT) cnt_d = cnt_q + CNT_W'(1);

    // The freshly counted completion feeds the pick, so the forced fetch follows
    // the LIMIT-th data hit directly.
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = pick(bus.iREN, d_req, cnt_d);
      IGRANT:  if (!bus.iREN) state_d = IDLE;
               else if (done) state_d = pick(bus.iREN, d_req, cnt_d);
      DGRANT:  if (!d_req) state_d = IDLE;
               else if (done) state_d = pick(bus.iREN, d_req, cnt_d);
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ramREN   = i_act || (d_act && !bus.dWEN);
    bus.ramWEN   = d_act && bus.dWEN;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iload    = '0;
    bus.dload    = '0;
    if (state_q == IGRANT) begin
      bus.ramaddr = bus.iaddr;
      bus.iload   = bus.ramload;
    end else if (state_q == DGRANT) begin
      bus.ramaddr = bus.daddr;
      if (bus.dWEN) bus.ramstore = bus.dstore;
      else          bus.dload    = bus.ramload;
    end
    bus.ihit       = ihit;
    bus.dhit       = dhit;
    bus.memerr     = (i_act || d_act) && (bus.ramstate == ERROR);
    bus.state      = state_q;
    bus.starve_cnt = cnt_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, directed scenarios, then randomized
// fetch/data traffic checked by a per-requester scoreboard.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 2;

  logic CLK = 1'b0;
  logic nRST;

  mem_arbiter_if #(.CNT_W(4)) bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [63:0] i_exp_q[$];
  logic [63:0] d_exp_q[$];

  word_t ram_mem[word_t];
  word_t ref_mem[word_t];

  int ram_lat  = 1;
  int err_pct  = 0;
  bit err_once = 1'b0;
  bit ram_err_now;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t init_word(input word_t a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic word_t ref_rd(input word_t a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic word_t ram_rd(input word_t a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  // Behavioural RAM: per access, some BUSY cycles then ACCESS (or an ERROR).
  initial begin
    bit in_prog;
    int left;
    in_prog      = 1'b0;
    left         = 0;
    ram_err_now  = 1'b0;
    bus.ramstate = FREE;
    bus.ramload  = '0;
    forever begin
      @(posedge CLK);
      #2;
      ram_err_now = 1'b0;
      if (!(bus.ramREN || bus.ramWEN)) begin
        in_prog      = 1'b0;
        bus.ramstate = FREE;
        bus.ramload  = $urandom;
      end else begin
        if (!in_prog) begin
          left    = (ram_lat < 0) ? int'($urandom_range(0, 3)) : ram_lat;
          in_prog = 1'b1;
        end
        if (left > 0) begin
          left--;
          bus.ramstate = BUSY;
          bus.ramload  = $urandom;
        end else begin
          in_prog = 1'b0;
          if (err_once || (int'($urandom_range(0, 99)) < err_pct)) begin
            err_once     = 1'b0;
            ram_err_now  = 1'b1;
            bus.ramstate = ERROR;
            bus.ramload  = $urandom;
          end else begin
            bus.ramstate = ACCESS;
            if (bus.ramWEN) begin
              ram_mem[bus.ramaddr] = bus.ramstore;
              bus.ramload          = $urandom;
            end else begin
              bus.ramload = ram_rd(bus.ramaddr);
            end
          end
        end
      end
    end
  end

  // Monitor: pops the expected {address, load} on every hit.
  initial begin
    logic [63:0] e;
    int d_in_row;
    d_in_row = 0;
    forever begin
      @(negedge CLK);
      if (nRST) begin
        if (bus.ihit || bus.dhit)
          check("hit_exclusive", 64'(bus.ihit & bus.dhit), 64'(0));
        if (bus.ihit) begin
          if (i_exp_q.size() == 0) check("ihit_unexpected", 64'(bus.ihit), 64'(0));
          else begin
            e = i_exp_q.pop_front();
            check("fetch_addr_load", {bus.ramaddr, bus.iload}, e);
          end
        end
        if (bus.dhit) begin
          if (d_exp_q.size() == 0) check("dhit_unexpected", 64'(bus.dhit), 64'(0));
          else begin
            e = d_exp_q.pop_front();
            check("data_addr_load", {bus.ramaddr, bus.dload}, e);
          end
        end
        if (bus.memerr || ram_err_now)
          check("memerr", 64'(bus.memerr), 64'(ram_err_now));
        if (bus.ihit || !bus.iREN) d_in_row = 0;
        else if (bus.dhit) begin
          d_in_row++;
          check("starve_bound", 64'(d_in_row > LIMIT), 64'(0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic fetch_txn(input word_t a, input bit may_flush);
    bit got;
    got       = 1'b0;
    bus.iaddr = a;
    bus.iREN  = 1'b1;
    i_exp_q.push_back({a, ref_rd(a)});
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (bus.ihit) begin
        got = 1'b1;
        break;
      end
      tick();
      if (may_flush && $urandom_range(0, 19) == 0) begin
        bus.iREN = 1'b0;
        void'(i_exp_q.pop_back());
        return;
      end
    end
    if (!got) begin
      check("fetch_timeout", 64'(got), 64'(1));
      bus.iREN = 1'b0;
      void'(i_exp_q.pop_back());
    end
    tick();
  endtask

  task automatic data_txn(input word_t a, input bit wr, input word_t v);
    bit got;
    got        = 1'b0;
    bus.daddr  = a;
    bus.dWEN   = wr;
    bus.dREN   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.dstore = wr ? v : word_t'($urandom);
    if (wr) begin
      ref_mem[a] = v;
      d_exp_q.push_back({a, 32'h0});
    end else begin
      d_exp_q.push_back({a, ref_rd(a)});
    end
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (bus.dhit) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) begin
      check("data_timeout", 64'(got), 64'(1));
      void'(d_exp_q.pop_back());
    end
    tick();
  endtask

  initial begin
    arbstate_t starve_exp[12];
    starve_exp = '{DGRANT, DGRANT, DGRANT, DGRANT, IGRANT, IGRANT,
                   DGRANT, DGRANT, DGRANT, DGRANT, IGRANT, IGRANT};

    nRST = 1'b0;
    bus.iREN = 1'b1;  bus.iaddr = 32'h40;
    bus.dREN = 1'b1;  bus.dWEN = 1'b0;  bus.daddr = 32'h100;  bus.dstore = 32'h1;
    settle(2);
    @(negedge CLK);
    check("rst_state",    64'(bus.state),      64'(IDLE));
    check("rst_ramREN",   64'(bus.ramREN),     64'(0));
    check("rst_ramWEN",   64'(bus.ramWEN),     64'(0));
    check("rst_ramaddr",  64'(bus.ramaddr),    64'(0));
    check("rst_ramstore", 64'(bus.ramstore),   64'(0));
    check("rst_hits",     64'({bus.ihit, bus.dhit, bus.memerr}), 64'(0));
    check("rst_loads",    {bus.iload, bus.dload}, 64'(0));
    check("rst_cnt",      64'(bus.starve_cnt), 64'(0));
    bus.iREN = 1'b0;  bus.dREN = 1'b0;
    tick();
    nRST = 1'b1;
    settle(2);

    // Fetch only, two BUSY cycles before ACCESS.
    ram_lat = 2;
    ram_mem[32'h40] = 32'h8C220004;
    ref_mem[32'h40] = 32'h8C220004;
    bus.iaddr = 32'h40;  bus.iREN = 1'b1;
    i_exp_q.push_back({32'h40, 32'h8C220004});
    @(negedge CLK);
    check("fetch_c0_ramREN", 64'(bus.ramREN), 64'(0));
    @(negedge CLK);
    check("fetch_c1_state",  64'(bus.state),   64'(IGRANT));
    check("fetch_c1_ram",    {31'h0, bus.ramREN, bus.ramaddr}, {31'h0, 1'b1, 32'h40});
    @(negedge CLK);
    check("fetch_c2_ihit",   64'(bus.ihit),    64'(0));
    @(negedge CLK);
    check("fetch_c3_ihit",   64'(bus.ihit),    64'(1));
    check("fetch_c3_iload",  64'(bus.iload),   64'(32'h8C220004));
    tick();
    bus.iREN = 1'b0;
    settle(3);

    // Store: write wins, dload stays zero.
    ram_lat = 1;
    bus.daddr = 32'h200;  bus.dstore = 32'hDEADBEEF;  bus.dWEN = 1'b1;
    ref_mem[32'h200] = 32'hDEADBEEF;
    d_exp_q.push_back({32'h200, 32'h0});
    @(negedge CLK);
    @(negedge CLK);
    check("store_ram_en",  64'({bus.ramWEN, bus.ramREN}), 64'(2'b10));
    check("store_ram_bus", {bus.ramaddr, bus.ramstore}, {32'h200, 32'hDEADBEEF});
    @(negedge CLK);
    check("store_dhit",    64'(bus.dhit),  64'(1));
    check("store_dload",   64'(bus.dload), 64'(0));
    tick();
    bus.dWEN = 1'b0;
    settle(3);
    check("store_mem", 64'(ram_rd(32'h200)), 64'(32'hDEADBEEF));

    // Simultaneous requests: data first, then the fetch with no idle gap.
    ram_lat = 0;
    bus.iaddr = 32'h44;  bus.iREN = 1'b1;
    bus.daddr = 32'h100; bus.dREN = 1'b1;
    d_exp_q.push_back({32'h100, ref_rd(32'h100)});
    d_exp_q.push_back({32'h104, ref_rd(32'h104)});
    i_exp_q.push_back({32'h44, ref_rd(32'h44)});
    @(negedge CLK);
    check("sim_c0_state", 64'(bus.state), 64'(IDLE));
    @(negedge CLK);
    check("sim_c1_state", 64'(bus.state), 64'(DGRANT));
    check("sim_c1_hit",   {31'h0, bus.dhit, bus.ramaddr}, {31'h0, 1'b1, 32'h100});
    tick();
    bus.daddr = 32'h104;
    @(negedge CLK);
    check("sim_c2_state", 64'(bus.state), 64'(DGRANT));
    tick();
    bus.dREN = 1'b0;
    @(negedge CLK);
    check("sim_c3_state", 64'(bus.state), 64'(IGRANT));
    check("sim_c3_ihit",  64'(bus.ihit),  64'(1));
    tick();
    bus.iREN = 1'b0;
    settle(3);

    // Starvation: both held, one BUSY cycle per access.
    ram_lat = 1;
    bus.iaddr = 32'h48;  bus.iREN = 1'b1;
    bus.daddr = 32'h108; bus.dREN = 1'b1;
    repeat (4) d_exp_q.push_back({32'h108, ref_rd(32'h108)});
    repeat (2) i_exp_q.push_back({32'h48, ref_rd(32'h48)});
    @(negedge CLK);
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      check($sformatf("starve_state_%0d", k + 1), 64'(bus.state), 64'(starve_exp[k]));
      if (k == 4 || k == 10) check("starve_cnt", 64'(bus.starve_cnt), 64'(LIMIT));
    end
    tick();
    bus.iREN = 1'b0;  bus.dREN = 1'b0;
    settle(3);

    // Flush: fetch dropped while its access is pending.
    ram_lat = 3;
    bus.iaddr = 32'h80;  bus.iREN = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("flush_c1_ramREN", 64'(bus.ramREN), 64'(1));
    tick();
    bus.iREN = 1'b0;
    @(negedge CLK);
    check("flush_c2", 64'({bus.ramREN, bus.ihit}), 64'(0));
    @(negedge CLK);
    check("flush_c3_state", 64'(bus.state), 64'(IDLE));
    settle(2);

    // ERROR completion: memerr pulse, no hit, then the re-grant succeeds.
    ram_lat  = 0;
    err_once = 1'b1;
    bus.daddr = 32'h300;  bus.dREN = 1'b1;
    d_exp_q.push_back({32'h300, ref_rd(32'h300)});
    @(negedge CLK);
    @(negedge CLK);
    check("err_c1", 64'({bus.memerr, bus.dhit}), 64'(2'b10));
    @(negedge CLK);
    check("err_c2_state", 64'(bus.state), 64'(DGRANT));
    check("err_c2", 64'({bus.memerr, bus.dhit}), 64'(2'b01));
    tick();
    bus.dREN = 1'b0;
    settle(3);

    // Reset in the middle of a store grant.
    ram_lat = 3;
    bus.daddr = 32'h400;  bus.dstore = 32'h12345678;  bus.dWEN = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_mid_pre", 64'({bus.state, bus.ramWEN}), 64'({DGRANT, 1'b1}));
    #1 nRST = 1'b0;
    #1;
    check("rst_mid_state", 64'(bus.state), 64'(IDLE));
    check("rst_mid_ram",   {bus.ramaddr, bus.ramstore}, 64'(0));
    check("rst_mid_ctl",   64'({bus.ramREN, bus.ramWEN, bus.dhit, bus.memerr}), 64'(0));
    check("rst_mid_dload", 64'(bus.dload), 64'(0));
    bus.dWEN = 1'b0;
    settle(2);
    nRST = 1'b1;
    settle(2);
    check("rst_mid_nowrite", 64'(ram_mem.exists(32'h400)), 64'(0));

    // Randomized concurrent traffic.
    ram_lat = -1;
    err_pct = 10;
    fork
      begin
        for (int k = 0; k < 80; k++) begin
          fetch_txn({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, 1'b1);
          if ($urandom_range(0, 2) == 0) begin
            bus.iREN = 1'b0;
            settle($urandom_range(1, 3));
          end
        end
        bus.iREN = 1'b0;
      end
      begin
        for (int k = 0; k < 120; k++) begin
          data_txn(32'h1000_0000 + 32'($urandom_range(0, 15)) * 4,
                   1'($urandom_range(0, 1)), word_t'($urandom));
          if ($urandom_range(0, 2) == 0) begin
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
            settle($urandom_range(1, 3));
          end
        end
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
      end
    join
    settle(5);
    check("i_queue_empty", 64'(i_exp_q.size()), 64'(0));
    check("d_queue_empty", 64'(d_exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
